rr_sel_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the 4-to-1 bit multiplexer and drives its 2-bit select.
- Four requesters compete for the shared mux path. The arbiter grants one at a time and holds the grant while the owner keeps requesting.
- Outputs a registered select, a one-hot grant and a busy flag that downstream logic uses to qualify the mux output.

---
 rtl/rr_sel_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_sel_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// Four-way round-robin arbiter driving the 2-bit select of a downstream 4:1 mux.
// Optional per-owner hold timeout is compiled in with `define RR_SEL_TIMEOUT_EN.
module rr_sel_arbiter #(
   parameter int N_REQ    = 4,
   parameter int SEL_W    = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             busy
);

   typedef enum logic {IDLE, OWNED} state_t;

   if (N_REQ != 4 || SEL_W != 2 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("rr_sel_arbiter: unsupported parameter set");
   end

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic             release_now;
   logic [SEL_W-1:0] srch_base;
   logic [N_REQ-1:0] srch_req;
   logic [SEL_W:0]   winner;

`ifdef RR_SEL_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;
`endif

   // Search order is base+1, base+2, base+3, base. Iterating from lowest to
   // highest priority lets the highest-priority hit overwrite the result.
   function automatic logic [SEL_W:0] find_winner(input logic [N_REQ-1:0] cand,
                                                  input logic [SEL_W-1:0] base);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = base + SEL_W'(i);
         if (cand[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      release_now = 1'b0;
      srch_base   = ptr;
      srch_req    = req;
      if (state == OWNED) begin
         release_now = !req[sel];
`ifdef RR_SEL_TIMEOUT_EN
         if (hold_cnt == HOLD_LAST) release_now = 1'b1;
`endif
         srch_base      = sel;
         srch_req[sel]  = 1'b0;
      end
   end

   assign winner = find_winner(srch_req, srch_base);

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= SEL_W'(N_REQ - 1);
         sel   <= '0;
         gnt   <= '0;
         busy  <= 1'b0;
`ifdef RR_SEL_TIMEOUT_EN
         hold_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (winner[SEL_W]) begin
                  state <= OWNED;
                  sel   <= winner[SEL_W-1:0];
                  gnt   <= N_REQ'(1) << winner[SEL_W-1:0];
                  busy  <= 1'b1;
`ifdef RR_SEL_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end
            end
            OWNED: begin
               if (release_now) begin
                  ptr <= sel;
                  if (winner[SEL_W]) begin
                     // Hand-over without an idle bubble.
                     sel <= winner[SEL_W-1:0];
                     gnt <= N_REQ'(1) << winner[SEL_W-1:0];
`ifdef RR_SEL_TIMEOUT_EN
                     hold_cnt <= '0;
                  end else if (req[sel]) begin
                     // Forced release with nobody waiting: owner keeps the path.
                     hold_cnt <= '0;
`endif
                  end else begin
                     state <= IDLE;
                     gnt   <= '0;
                     busy  <= 1'b0;
                  end
               end else begin
`ifdef RR_SEL_TIMEOUT_EN
                  hold_cnt <= hold_cnt + 8'd1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus random request
// traffic compared against an integer-level round-robin reference model.
module tb_rr_sel_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: owner index or -1 when idle.
   int m_owner;
   int m_ptr;
   int m_sel;
   int m_hold;

   rr_sel_arbiter #(.N_REQ(4), .SEL_W(2), .MAX_HOLD(MAX_HOLD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .sel  (sel),
      .gnt  (gnt),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 3;
      m_sel   = 0;
      m_hold  = 0;
   endtask

   // One clock of arbitration, decided from the requests visible before the edge.
   task automatic model_step(input logic [3:0] r);
      logic [3:0] cand;
      bit         rel;
      int         base;
      int         w;
      cand = r;
      if (m_owner < 0) begin
         rel  = 1;
         base = m_ptr;
      end else begin
         rel = (r[m_owner] == 1'b0);
`ifdef RR_SEL_TIMEOUT_EN
         if (m_hold == MAX_HOLD - 1) rel = 1;
`endif
         base = m_owner;
         cand[m_owner] = 1'b0;
      end
      if (!rel) begin
         m_hold++;
         return;
      end
      if (m_owner >= 0) m_ptr = m_owner;
      w = -1;
      for (int k = 1; k <= 4; k++) begin
         if (w < 0 && cand[(base + k) % 4]) w = (base + k) % 4;
      end
      if (w >= 0) begin
         m_owner = w;
         m_sel   = w;
         m_hold  = 0;
      end else if (m_owner >= 0 && r[m_owner]) begin
         m_hold = 0;
      end else begin
         m_owner = -1;
      end
   endtask

   task automatic compare(input string tag);
      check({tag, ".gnt"},  32'(gnt),  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check({tag, ".busy"}, 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      check({tag, ".sel"},  32'(sel),  32'(m_sel));
   endtask

   task automatic step(input logic [3:0] r, input string tag);
      @(negedge clk);
      req = r;
      model_step(r);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   initial begin
      logic [3:0] r;
      rst_n = 1'b0;
      req   = 4'b0000;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset.gnt",  32'(gnt),  32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.sel",  32'(sel),  32'd0);

      // All requesting; each owner drops its request for one cycle in turn.
      step(4'b1111, "all_first");
      check("all_first_const", 32'(gnt), 32'h1);
      for (int i = 0; i < 5; i++) begin
         r = 4'b1111;
         r[i % 4] = 1'b0;
         step(r, "all_release");
         check("all_busy_no_gap", 32'(busy), 32'd1);
         step(4'b1111, "all_hold");
      end
      step(4'b0000, "all_idle");
      step(4'b0000, "all_idle2");

      // Single requester for five cycles, then idle.
      for (int i = 0; i < 5; i++) step(4'b0100, "single");
      check("single_sel_const", 32'(sel), 32'd2);
      step(4'b0000, "single_drop");
      check("single_drop_busy", 32'(busy), 32'd0);

      // Owner 1 holds while 3 and 0 arrive; 3 must precede 0.
      step(4'b0010, "own1");
      step(4'b1011, "own1_hold");
      check("own1_hold_const", 32'(gnt), 32'h2);
      step(4'b1001, "own1_release");
      check("own1_to3_const", 32'(gnt), 32'h8);
      step(4'b0001, "own3_release");
      check("own3_to0_const", 32'(gnt), 32'h1);
      step(4'b0000, "own_idle");

      // Asynchronous reset between edges while requester 2 owns the path.
      step(4'b0100, "pre_rst");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.gnt",  32'(gnt),  32'd0);
      check("async_rst.busy", 32'(busy), 32'd0);
      check("async_rst.sel",  32'(sel),  32'd0);
      model_reset();
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, "post_rst");
      check("post_rst_const", 32'(gnt), 32'h1);
      step(4'b0000, "post_rst_idle");

      // Two requesters held constantly; then a lone requester held.
      for (int i = 0; i < 20; i++) step(4'b0011, "pair_hold");
      step(4'b0000, "pair_idle");
      for (int i = 0; i < 20; i++) step(4'b0001, "lone_hold");
      check("lone_busy", 32'(busy), 32'd1);

      // Random traffic: each request bit toggles with probability 1/4 per cycle.
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         end
         step(r, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
